wb_arbiter: RTL

Writeback arbiter that drives the general-purpose register file write port (`I_rd_we`/`I_rd_waddr`/`I_rd_wdata`) from two producers: the single-cycle ALU and the multi-cycle load/store unit. It sits between execute/LSU and the register file.
- Merges both result streams onto the one write port, with load data taking priority.
- Buffers one displaced ALU result.
- Formats sub-word load data.
- Keeps a pending-load scoreboard that stalls decode on RAW/WAW hazards against outstanding loads.

---
 rtl/wb_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Writeback arbiter for the general-purpose register file write port.
//   Merges single-cycle ALU results and multi-cycle load responses onto one
//   registered write port. Loads have priority, and one ALU result displaced
//   by a load is parked in a hold register. A pending-load scoreboard stalls
//   decode on RAW/WAW hazards against outstanding loads.
//
//   Optional feature macro: WB_LOAD_EXT_EN
//     defined   - sub-word extraction, sign/zero extension and misalign detect
//     undefined - load data written unmodified, O_misalign tied low
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   I_alu_valid/rd/data           ALU result; O_alu_ready accepts it
//   I_lsu_valid/rd/rdata          load response; O_lsu_ready accepts it
//   I_lsu_funct3, I_lsu_off       load type and byte offset in the word
//   I_ld_issue, I_ld_issue_rd     load issued this cycle, its destination
//   I_rs1_raddr/I_rs2_raddr/I_dec_rd  decode operands checked for hazards
//   O_stall                       decode must hold
//   O_rd_we/O_rd_waddr/O_rd_wdata registered register-file write port
//   O_misalign                    one-cycle pulse on a misaligned load
module wb_arbiter #(
  parameter int REG_NUM = 32,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            I_alu_valid,
  input  logic [4:0]      I_alu_rd,
  input  logic [XLEN-1:0] I_alu_data,
  output logic            O_alu_ready,
  input  logic            I_lsu_valid,
  input  logic [4:0]      I_lsu_rd,
  input  logic [XLEN-1:0] I_lsu_rdata,
  input  logic [2:0]      I_lsu_funct3,
  input  logic [1:0]      I_lsu_off,
  output logic            O_lsu_ready,
  input  logic            I_ld_issue,
  input  logic [4:0]      I_ld_issue_rd,
  input  logic [4:0]      I_rs1_raddr,
  input  logic [4:0]      I_rs2_raddr,
  input  logic [4:0]      I_dec_rd,
  output logic            O_stall,
  output logic            O_rd_we,
  output logic [4:0]      O_rd_waddr,
  output logic [XLEN-1:0] O_rd_wdata,
  output logic            O_misalign
);

  logic               lsu_ready_q;
  logic               hold_v;
  logic [4:0]         hold_rd;
  logic [XLEN-1:0]    hold_data;
  logic [REG_NUM-1:0] pend;
  logic [REG_NUM-1:0] pend_set;
  logic [REG_NUM-1:0] pend_clr;
  logic               lsu_acc;
  logic               alu_acc;
  logic [XLEN-1:0]    ld_data;
  logic               ld_mis;

  assign O_lsu_ready = lsu_ready_q;
  assign O_alu_ready = !hold_v;
  assign lsu_acc     = I_lsu_valid && lsu_ready_q;
  assign alu_acc     = I_alu_valid && !hold_v;

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Load formatting: pick the addressed byte/halfword and extend it.
  // Every encoding that is not a byte or halfword load is a full-word load.
  always_comb begin
    case (I_lsu_off)
      2'd0:    ld_byte = I_lsu_rdata[7:0];
      2'd1:    ld_byte = I_lsu_rdata[15:8];
      2'd2:    ld_byte = I_lsu_rdata[23:16];
      default: ld_byte = I_lsu_rdata[31:24];
    endcase
    ld_half = I_lsu_off[1] ? I_lsu_rdata[31:16] : I_lsu_rdata[15:0];
    ld_data = I_lsu_rdata;
    ld_mis  = 1'b0;
    case (I_lsu_funct3)
      3'b000: ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100: ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001: begin
        ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
        ld_mis  = I_lsu_off[0];
      end
      3'b101: begin
        ld_data = {{(XLEN-16){1'b0}}, ld_half};
        ld_mis  = I_lsu_off[0];
      end
      default: ld_mis = (I_lsu_off != 2'd0);
    endcase
  end
`else
  // The LSU delivers pre-formatted data; type and offset are not used.
  wire unused_ld_fmt = &{1'b0, I_lsu_funct3, I_lsu_off};

  assign ld_data = I_lsu_rdata;
  assign ld_mis  = 1'b0;
`endif

  // Scoreboard update vectors; a set of the same bit overrides its clear.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (I_ld_issue && (I_ld_issue_rd != 5'd0)) pend_set[I_ld_issue_rd] = 1'b1;
    if (lsu_acc) pend_clr[I_lsu_rd] = 1'b1;
  end

  assign O_stall = ((I_rs1_raddr != 5'd0) && pend[I_rs1_raddr]) ||
                   ((I_rs2_raddr != 5'd0) && pend[I_rs2_raddr]) ||
                   ((I_dec_rd    != 5'd0) && pend[I_dec_rd]);

  // Write select: accepted load, else parked ALU result, else live ALU
  // result. An ALU result accepted alongside a load is parked for later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsu_ready_q <= 1'b0;
      hold_v      <= 1'b0;
      hold_rd     <= '0;
      hold_data   <= '0;
      pend        <= '0;
      O_rd_we     <= 1'b0;
      O_rd_waddr  <= '0;
      O_rd_wdata  <= '0;
      O_misalign  <= 1'b0;
    end else begin
      lsu_ready_q <= 1'b1;
      pend        <= (pend & ~pend_clr) | pend_set;
      O_misalign  <= 1'b0;
      if (lsu_acc) begin
        O_rd_we    <= (I_lsu_rd != 5'd0) && !ld_mis;
        O_rd_waddr <= I_lsu_rd;
        O_rd_wdata <= ld_data;
        O_misalign <= ld_mis;
        if (alu_acc) begin
          hold_v    <= 1'b1;
          hold_rd   <= I_alu_rd;
          hold_data <= I_alu_data;
        end
      end else if (hold_v) begin
        O_rd_we    <= (hold_rd != 5'd0);
        O_rd_waddr <= hold_rd;
        O_rd_wdata <= hold_data;
        hold_v     <= 1'b0;
      end else if (alu_acc) begin
        O_rd_we    <= (I_alu_rd != 5'd0);
        O_rd_waddr <= I_alu_rd;
        O_rd_wdata <= I_alu_data;
      end else begin
        O_rd_we <= 1'b0;
      end
    end
  end

endmodule
